// File: rtl/rd_req_tagger.sv
// -----------------------------------------------------------------------------
// rd_req_tagger
//
// Splits DMA read requests (counted in 16-byte beats) into PCIe memory-read
// requests. No request exceeds MAX_RD_BEATS, and no request crosses a 4 KB
// address boundary. Each request is given the lowest-index free tag and
// reserves reorder-buffer credits for its beats. One cycle before a request is
// presented downstream, the block writes the sequence index of that request's
// last beat into the reorder buffer's tag_seq_end table.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   upstream request handshake (ready only in IDLE)
//   req_addr, req_beats   request byte address (bits [3:0] ignored) and length
//   mrd_valid/mrd_ready   downstream memory-read handshake
//   mrd_addr/beats/tag    memory-read request fields, stable while stalled
//   tse_en/val/tag        one-cycle write into the reorder tag_seq_end table
//   tag_free_en/tag_free  release of a tag whose final completion arrived
//   buf_pop               one beat drained from the reorder buffer (+1 credit)
//   busy                  request in progress or any tag still outstanding
// -----------------------------------------------------------------------------
module rd_req_tagger #(
    parameter int MAX_RD_BEATS = 32,
    parameter int NUM_TAGS     = 32,
    parameter int BUF_SIZE     = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [15:0] req_beats,
    output logic        mrd_valid,
    input  logic        mrd_ready,
    output logic [63:0] mrd_addr,
    output logic [8:0]  mrd_beats,
    output logic [7:0]  mrd_tag,
    output logic        tse_en,
    output logic [31:0] tse_val,
    output logic [7:0]  tse_tag,
    input  logic        tag_free_en,
    input  logic [7:0]  tag_free,
    input  logic        buf_pop,
    output logic        busy
);

    localparam int CRED_W = $clog2(BUF_SIZE + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_ALLOC = 3'd2,
        ST_TSE   = 3'd3,
        ST_ISSUE = 3'd4
    } state_e;

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [63:0]         addr_q,      addr_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [8:0]          chunk_q,     chunk_d;
    logic [31:0]         seq_q,       seq_d;
    logic [CRED_W-1:0]   credits_q,   credits_d;
    logic [NUM_TAGS-1:0] pool_q,      pool_d;

    logic                req_ready_q, req_ready_d;
    logic                mrd_valid_q, mrd_valid_d;
    logic [63:0]         mrd_addr_q,  mrd_addr_d;
    logic [8:0]          mrd_beats_q, mrd_beats_d;
    logic [7:0]          mrd_tag_q,   mrd_tag_d;
    logic                tse_en_q,    tse_en_d;
    logic [31:0]         tse_val_q,   tse_val_d;
    logic [7:0]          tse_tag_q,   tse_tag_d;
    logic                busy_q,      busy_d;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic                tag_found_s;
    logic [7:0]          alloc_tag_s;
    logic                credit_ok_s;
    logic                grant_s;
    logic [8:0]          boundary_beats_s;
    logic [8:0]          rem_cap_s;
    logic [8:0]          chunk_calc_s;
    logic [31:0]         cred_next_s;
    logic [NUM_TAGS-1:0] free_mask_s;
    logic [NUM_TAGS-1:0] alloc_mask_s;

    // Beats left before the next 4 KB boundary; the address is 16-byte
    // aligned, so this is 256 minus the beat offset inside the 4 KB page.
    assign boundary_beats_s = 9'd256 - {1'b0, addr_q[11:4]};

    // When remaining is below MAX_RD_BEATS (<= 256) it fits in 9 bits.
    assign rem_cap_s = (remaining_q >= 16'(MAX_RD_BEATS)) ? 9'(MAX_RD_BEATS)
                                                          : remaining_q[8:0];

    assign chunk_calc_s = (rem_cap_s < boundary_beats_s) ? rem_cap_s
                                                         : boundary_beats_s;

    // Search the registered pool only, so a tag freed this cycle becomes
    // allocatable one cycle later.
    // Lowest-index free tag search
    always_comb begin
        tag_found_s = 1'b0;
        alloc_tag_s = 8'd0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            tag_found_s = tag_found_s | ~pool_q[i];
            alloc_tag_s = pool_q[i] ? alloc_tag_s : 8'(i);
        end
    end

    assign credit_ok_s = (32'(credits_q) >= 32'(chunk_q));
    assign grant_s     = (state_q == ST_ALLOC) && tag_found_s && credit_ok_s;

    // Tag pool update masks; out-of-range or already-free releases clear nothing
    always_comb begin
        free_mask_s  = '0;
        alloc_mask_s = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            free_mask_s[i]  = tag_free_en && (tag_free == 8'(i));
            alloc_mask_s[i] = grant_s && (alloc_tag_s == 8'(i));
        end
    end

    // An allocated tag is free in pool_q, so a release cannot target it in the
    // same cycle; applying the clear first and the set second is order-safe.
    assign pool_d = (pool_q & ~free_mask_s) | alloc_mask_s;

    // Credit accounting with saturation at the buffer depth
    always_comb begin
        cred_next_s = 32'(credits_q)
                    - (grant_s ? 32'(chunk_q) : 32'd0)
                    + (buf_pop ? 32'd1 : 32'd0);
        if (cred_next_s > 32'(BUF_SIZE)) begin
            credits_d = CRED_W'(BUF_SIZE);
        end else begin
            credits_d = CRED_W'(cred_next_s);
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and next-output logic
    // ---------------------------------------------------------------------
    // Request splitting state machine
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        seq_d       = seq_q;
        tse_val_d   = tse_val_q;
        tse_tag_d   = tse_tag_q;
        mrd_addr_d  = mrd_addr_q;
        mrd_beats_d = mrd_beats_q;
        mrd_tag_d   = mrd_tag_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr & ~64'hF;
                    remaining_d = req_beats;
                    if (req_beats != 16'd0) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CALC: begin
                chunk_d = chunk_calc_s;
                state_d = ST_ALLOC;
            end

            ST_ALLOC: begin
                if (grant_s) begin
                    tse_val_d = seq_q + 32'(chunk_q) - 32'd1;
                    tse_tag_d = alloc_tag_s;
                    state_d   = ST_TSE;
                end else begin
                    state_d = ST_ALLOC;
                end
            end

            ST_TSE: begin
                // Request fields are captured once here and then held for
                // the whole time mrd_valid is asserted.
                mrd_addr_d  = addr_q;
                mrd_beats_d = chunk_q;
                mrd_tag_d   = tse_tag_q;
                state_d     = ST_ISSUE;
            end

            ST_ISSUE: begin
                if (mrd_ready) begin
                    seq_d       = seq_q + 32'(chunk_q);
                    addr_d      = addr_q + 64'({chunk_q, 4'b0000});
                    remaining_d = remaining_q - 16'(chunk_q);
                    if (remaining_d != 16'd0) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        req_ready_d = (state_d == ST_IDLE);
        mrd_valid_d = (state_d == ST_ISSUE);
        tse_en_d    = (state_d == ST_TSE);
        busy_d      = (state_d != ST_IDLE) || (pool_d != '0);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 64'd0;
            remaining_q <= 16'd0;
            chunk_q     <= 9'd0;
            seq_q       <= 32'd0;
            credits_q   <= CRED_W'(BUF_SIZE);
            pool_q      <= '0;
            req_ready_q <= 1'b1;
            mrd_valid_q <= 1'b0;
            mrd_addr_q  <= 64'd0;
            mrd_beats_q <= 9'd0;
            mrd_tag_q   <= 8'd0;
            tse_en_q    <= 1'b0;
            tse_val_q   <= 32'd0;
            tse_tag_q   <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            seq_q       <= seq_d;
            credits_q   <= credits_d;
            pool_q      <= pool_d;
            req_ready_q <= req_ready_d;
            mrd_valid_q <= mrd_valid_d;
            mrd_addr_q  <= mrd_addr_d;
            mrd_beats_q <= mrd_beats_d;
            mrd_tag_q   <= mrd_tag_d;
            tse_en_q    <= tse_en_d;
            tse_val_q   <= tse_val_d;
            tse_tag_q   <= tse_tag_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mrd_valid = mrd_valid_q;
    assign mrd_addr  = mrd_addr_q;
    assign mrd_beats = mrd_beats_q;
    assign mrd_tag   = mrd_tag_q;
    assign tse_en    = tse_en_q;
    assign tse_val   = tse_val_q;
    assign tse_tag   = tse_tag_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rd_req_tagger.sv
// -----------------------------------------------------------------------------
// tb_rd_req_tagger
//
// Bench for rd_req_tagger: directed scenarios (reset, single request, 4 KB
// split, credit stall, tag stall, backpressure and reset) followed by random
// requests with random backpressure, tag releases and buffer pops.
// -----------------------------------------------------------------------------
module tb_rd_req_tagger;

    localparam int NT = 32;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [15:0] req_beats;
    logic        mrd_valid;
    logic        mrd_ready;
    logic [63:0] mrd_addr;
    logic [8:0]  mrd_beats;
    logic [7:0]  mrd_tag;
    logic        tse_en;
    logic [31:0] tse_val;
    logic [7:0]  tse_tag;
    logic        tag_free_en;
    logic [7:0]  tag_free;
    logic        buf_pop;
    logic        busy;

    rd_req_tagger #(
        .MAX_RD_BEATS(32),
        .NUM_TAGS    (32),
        .BUF_SIZE    (512)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_beats  (req_beats),
        .mrd_valid  (mrd_valid),
        .mrd_ready  (mrd_ready),
        .mrd_addr   (mrd_addr),
        .mrd_beats  (mrd_beats),
        .mrd_tag    (mrd_tag),
        .tse_en     (tse_en),
        .tse_val    (tse_val),
        .tse_tag    (tse_tag),
        .tag_free_en(tag_free_en),
        .tag_free   (tag_free),
        .buf_pop    (buf_pop),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] val;
        logic [7:0]  exp_tag;
    } tse_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [8:0]  beats;
        logic [7:0]  tag;
        logic        tse_before;
    } mrd_t;

    tse_t tse_q[$];
    mrd_t mrd_q[$];

    int errors = 0;
    int checks = 0;
    int tse_idx = 0;
    int mrd_idx = 0;
    int scan_idx = 0;
    int issued_beats = 0;
    int popped = 0;
    logic [NT-1:0] busy_main;
    logic [31:0]   model_seq;
    logic          rnd_mode = 1'b0;

    // Tag pool model: lowest free tag, releases visible one cycle later.
    logic [NT-1:0] model_pool;
    logic [NT-1:0] start_prev;
    logic [NT-1:0] start_cur;
    logic          prev_tse;
    logic          prev_mv;
    logic          rise_ok;

    function automatic logic [7:0] lowest_free(input logic [NT-1:0] p);
        logic [7:0] r;
        r = 8'hFF;
        for (int i = NT - 1; i >= 0; i--) begin
            if (!p[i]) r = 8'(i);
        end
        return r;
    endfunction

    initial begin
        logic [7:0] et;
        model_pool = '0;
        start_prev = '0;
        prev_tse   = 1'b0;
        prev_mv    = 1'b0;
        rise_ok    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_pool = '0;
                start_prev = '0;
                prev_tse   = 1'b0;
                prev_mv    = 1'b0;
            end else begin
                if (tse_en) begin
                    // Grant happened in the previous cycle.
                    et = lowest_free(start_prev);
                    tse_q.push_back('{tag: tse_tag, val: tse_val, exp_tag: et});
                    if (et < 8'(NT)) model_pool[et[4:0]] = 1'b1;
                end
                start_cur = model_pool;
                if (mrd_valid && !prev_mv) rise_ok = prev_tse;
                if (mrd_valid && mrd_ready) begin
                    mrd_q.push_back('{addr: mrd_addr, beats: mrd_beats,
                                      tag: mrd_tag, tse_before: rise_ok});
                end
                if (tag_free_en && (tag_free < 8'(NT))) model_pool[tag_free[4:0]] = 1'b0;
                start_prev = start_cur;
                prev_tse   = tse_en;
                prev_mv    = mrd_valid;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", nm, obs, exp);
        end
    endtask

    task automatic drive_random();
        int r;
        int st;
        logic found;
        while (scan_idx < mrd_q.size()) begin
            busy_main[mrd_q[scan_idx].tag[4:0]] = 1'b1;
            issued_beats += int'(mrd_q[scan_idx].beats);
            scan_idx++;
        end
        mrd_ready   = ($urandom_range(0, 3) != 0);
        tag_free_en = 1'b0;
        tag_free    = 8'd0;
        r = $urandom_range(0, 15);
        if (r < 5) begin
            st = $urandom_range(0, NT - 1);
            found = 1'b0;
            for (int k = 0; k < NT; k++) begin
                if (!found && busy_main[(st + k) % NT]) begin
                    found = 1'b1;
                    tag_free_en = 1'b1;
                    tag_free = 8'((st + k) % NT);
                    busy_main[(st + k) % NT] = 1'b0;
                end
            end
        end else if (r == 5) begin
            tag_free_en = 1'b1;
            tag_free    = 8'($urandom_range(NT, 255));
        end
        buf_pop = (popped < issued_beats) && ($urandom_range(0, 1) == 1);
        if (buf_pop) popped++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) drive_random();
    endtask

    task automatic resync();
        tse_idx      = tse_q.size();
        mrd_idx      = mrd_q.size();
        scan_idx     = mrd_q.size();
        busy_main    = '0;
        issued_beats = 0;
        popped       = 0;
        model_seq    = 32'd0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req_valid   = 1'b0;
        buf_pop     = 1'b0;
        tag_free_en = 1'b0;
        tag_free    = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        resync();
    endtask

    task automatic send(input logic [63:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        chk("send_ready", 64'(req_ready), 64'd1);
        req_addr  = a;
        req_beats = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // etag < 0 means the tag comes from the pool model.
    task automatic wait_chunk(input string nm, input logic [63:0] ea, input int eb,
                              input logic [31:0] ev, input int etag);
        int n;
        tse_t tr;
        mrd_t mr;
        n = 0;
        while (mrd_q.size() <= mrd_idx && n < 4000) begin
            tick();
            n++;
        end
        chk({nm, "_seen"}, 64'((mrd_q.size() > mrd_idx) && (tse_q.size() > tse_idx)), 64'd1);
        if ((mrd_q.size() > mrd_idx) && (tse_q.size() > tse_idx)) begin
            tr = tse_q[tse_idx];
            mr = mrd_q[mrd_idx];
            chk({nm, "_addr"}, mr.addr, ea);
            chk({nm, "_beats"}, 64'(mr.beats), 64'(eb));
            chk({nm, "_tseval"}, 64'(tr.val), 64'(ev));
            chk({nm, "_tagmatch"}, 64'(mr.tag), 64'(tr.tag));
            chk({nm, "_tse_lead"}, 64'(mr.tse_before), 64'd1);
            if (etag >= 0) chk({nm, "_tag"}, 64'(tr.tag), 64'(etag));
            else           chk({nm, "_tag"}, 64'(tr.tag), 64'(tr.exp_tag));
            tse_idx++;
            mrd_idx++;
        end
    endtask

    initial begin
        int n;
        int n0;
        logic [63:0] a;
        logic [63:0] ac;
        int b;
        int rem;
        int ch;
        int lim;

        rst = 1'b1; req_valid = 1'b0; req_addr = 64'd0; req_beats = 16'd0;
        mrd_ready = 1'b1; tag_free_en = 1'b0; tag_free = 8'd0; buf_pop = 1'b0;
        busy_main = '0; model_seq = 32'd0;

        // Reset then idle
        do_reset();
        repeat (5) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mrd_valid", 64'(mrd_valid), 64'd0);
        chk("rst_tse_en", 64'(tse_en), 64'd0);
        chk("rst_mrd_addr", mrd_addr, 64'd0);
        chk("rst_mrd_beats", 64'(mrd_beats), 64'd0);
        chk("rst_mrd_tag", 64'(mrd_tag), 64'd0);
        chk("rst_tse_val", 64'(tse_val), 64'd0);
        chk("rst_tse_tag", 64'(tse_tag), 64'd0);

        // Single request with cycle-accurate timing
        send(64'h1000, 16'd8);
        chk("c1_req_ready", 64'(req_ready), 64'd0);
        chk("c1_busy", 64'(busy), 64'd1);
        tick();
        chk("c2_tse_en", 64'(tse_en), 64'd0);
        tick();
        chk("c3_tse_en", 64'(tse_en), 64'd1);
        chk("c3_tse_tag", 64'(tse_tag), 64'd0);
        chk("c3_tse_val", 64'(tse_val), 64'd7);
        chk("c3_mrd_valid", 64'(mrd_valid), 64'd0);
        tick();
        chk("c4_mrd_valid", 64'(mrd_valid), 64'd1);
        chk("c4_mrd_addr", mrd_addr, 64'h1000);
        chk("c4_mrd_beats", 64'(mrd_beats), 64'd8);
        chk("c4_mrd_tag", 64'(mrd_tag), 64'd0);
        chk("c4_tse_en", 64'(tse_en), 64'd0);
        tick();
        chk("c5_mrd_valid", 64'(mrd_valid), 64'd0);
        chk("c5_req_ready", 64'(req_ready), 64'd1);
        chk("c5_busy_tag_out", 64'(busy), 64'd1);
        tag_free_en = 1'b1; tag_free = 8'd0;
        tick();
        tag_free_en = 1'b0;
        chk("free_busy_low", 64'(busy), 64'd0);
        wait_chunk("single", 64'h1000, 8, 32'd7, 0);

        // 4 KB boundary split
        do_reset();
        send(64'h0F80, 16'd40);
        wait_chunk("b4k_0", 64'h0F80, 8, 32'd7, 0);
        wait_chunk("b4k_1", 64'h1000, 32, 32'd39, 1);

        // Credit stall
        do_reset();
        send(64'h0, 16'd1024);
        for (int i = 0; i < 16; i++) begin
            wait_chunk("cred", 64'(i * 512), 32, 32'(i * 32 + 31), i);
        end
        repeat (20) tick();
        chk("cred_stall_no_tse", 64'(tse_q.size() - tse_idx), 64'd0);
        chk("cred_stall_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 32; i++) begin
            buf_pop = 1'b1;
            tick();
        end
        buf_pop = 1'b0;
        chk("cred_32pop_not_yet", 64'(tse_q.size() - tse_idx), 64'd0);
        wait_chunk("cred_17", 64'(16 * 512), 32, 32'd543, 16);

        // Tag stall
        do_reset();
        for (int i = 0; i < 33; i++) send(64'(i * 16), 16'd1);
        for (int i = 0; i < 32; i++) wait_chunk("tagst", 64'(i * 16), 1, 32'(i), i);
        repeat (10) tick();
        chk("tag_stall_no_tse", 64'(tse_q.size() - tse_idx), 64'd0);
        tag_free_en = 1'b1; tag_free = 8'd5;
        tick();
        tag_free_en = 1'b0;
        wait_chunk("tagst_33", 64'(32 * 16), 1, 32'd32, 5);

        // Backpressure and reset in ISSUE
        do_reset();
        mrd_ready = 1'b0;
        send(64'h2000, 16'd4);
        n = 0;
        while (mrd_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("bp_valid", 64'(mrd_valid), 64'd1);
        n0 = tse_q.size();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 64'(mrd_valid), 64'd1);
            chk("bp_hold_addr", mrd_addr, 64'h2000);
            chk("bp_hold_beats", 64'(mrd_beats), 64'd4);
            chk("bp_hold_tag", 64'(mrd_tag), 64'd0);
            chk("bp_no_tse", 64'(tse_en), 64'd0);
        end
        chk("bp_tse_count", 64'(tse_q.size()), 64'(n0));
        rst = 1'b1;
        tick();
        chk("rst_iss_mrd_valid", 64'(mrd_valid), 64'd0);
        chk("rst_iss_req_ready", 64'(req_ready), 64'd1);
        chk("rst_iss_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        mrd_ready = 1'b1;
        resync();
        send(64'h3000, 16'd5);
        wait_chunk("post_rst", 64'h3000, 5, 32'd4, 0);

        // Random requests against the splitting model
        do_reset();
        rnd_mode = 1'b1;
        for (int r = 0; r < 25; r++) begin
            a = {32'($urandom), 32'($urandom)} & ~64'hF;
            if ($urandom_range(0, 1) == 1) a[11:8] = 4'hF;
            b = ((r % 6) == 5) ? 0 : $urandom_range(1, 150);
            send(a, 16'(b));
            if (b == 0) begin
                repeat (3) tick();
                chk("zero_beats_idle", 64'(req_ready), 64'd1);
                chk("zero_beats_no_tse", 64'(tse_q.size() - tse_idx), 64'd0);
            end else begin
                rem = b;
                ac  = a;
                while (rem > 0) begin
                    lim = (4096 - int'(ac[11:0])) / 16;
                    ch  = rem;
                    if (ch > 32)  ch = 32;
                    if (ch > lim) ch = lim;
                    wait_chunk("rnd", ac, ch, model_seq + 32'(ch) - 32'd1, -1);
                    model_seq = model_seq + 32'(ch);
                    ac  = ac + 64'(ch * 16);
                    rem = rem - ch;
                end
            end
        end
        rnd_mode = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
